// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter: return-tag encoding,
// default bus widths and a saturating-increment helper for the stats counters.
package vram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SO   = 2'd1,
        TAG_RD   = 2'd2,
        TAG_CPU  = 2'd3
    } tag_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester handshakes and VRAM port bundle; slave is the arbiter side,
// master is the requesters plus the memory.
interface vram_port_arbiter_if
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              i_so_req;
    logic [ADDR_W-1:0] i_so_addr;
    logic              o_so_gnt;
    logic              o_so_rvalid;

    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_gnt;
    logic              o_rd_rvalid;

    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_gnt;
    logic              o_cpu_rvalid;

    logic [DATA_W-1:0] o_rdata;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_so_req, i_so_addr, i_rd_req, i_rd_addr,
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_mem_rdata,
        output o_so_gnt, o_so_rvalid, o_rd_gnt, o_rd_rvalid,
        output o_cpu_gnt, o_cpu_rvalid, o_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_so_req, i_so_addr, i_rd_req, i_rd_addr,
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_mem_rdata,
        input  o_so_gnt, o_so_rvalid, o_rd_gnt, o_rd_rvalid,
        input  o_cpu_gnt, o_cpu_rvalid, o_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/vram_port_arbiter_return_pipe.sv
// vram_return_pipe: MEM_LAT-deep shift register of read-return tags with a
// one-hot rvalid decode at the output stage.
module vram_return_pipe
    import vram_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_e i_tag,
    output logic o_so_rvalid,
    output logic o_rd_rvalid,
    output logic o_cpu_rvalid
);

    tag_e r_tag [MEM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                r_tag[i] <= TAG_NONE;
            end
        end else begin
            r_tag[0] <= i_tag;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        o_so_rvalid  = 1'b0;
        o_rd_rvalid  = 1'b0;
        o_cpu_rvalid = 1'b0;
        if (!reset) begin
            case (r_tag[MEM_LAT-1])
                TAG_SO:  o_so_rvalid  = 1'b1;
                TAG_RD:  o_rd_rvalid  = 1'b1;
                TAG_CPU: o_cpu_rvalid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Three-way VRAM arbiter (scanout > render/CPU round-robin, CPU starvation bound).
// Optional grant/conflict statistics enabled by defining VRAM_ARB_STATS_EN.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vram_port_arbiter_if.slave   bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]          o_stat_so_cnt,
    output logic [15:0]          o_stat_rd_cnt,
    output logic [15:0]          o_stat_cpu_cnt,
    output logic [15:0]          o_stat_conflict_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  r_starve;
    logic              r_rr_last;
    tag_e              w_win;
    tag_e              w_push;
    logic              w_force;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_force = (r_starve == CNT_W'(STARVE_MAX)) && bus.i_cpu_req;

    // Winner selection; requests are masked entirely while in reset.
    always_comb begin
        w_win = TAG_NONE;
        if (!reset) begin
            if (w_force)
                w_win = TAG_CPU;
            else if (bus.i_so_req)
                w_win = TAG_SO;
            else if (bus.i_rd_req && bus.i_cpu_req)
                w_win = r_rr_last ? TAG_RD : TAG_CPU;
            else if (bus.i_rd_req)
                w_win = TAG_RD;
            else if (bus.i_cpu_req)
                w_win = TAG_CPU;
        end
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        case (w_win)
            TAG_SO:  w_addr = bus.i_so_addr;
            TAG_RD:  w_addr = bus.i_rd_addr;
            TAG_CPU: begin
                w_addr  = bus.i_cpu_addr;
                w_wdata = bus.i_cpu_wdata;
            end
            default: ;
        endcase
    end

    assign bus.o_so_gnt    = (w_win == TAG_SO);
    assign bus.o_rd_gnt    = (w_win == TAG_RD);
    assign bus.o_cpu_gnt   = (w_win == TAG_CPU);
    assign bus.o_mem_en    = (w_win != TAG_NONE);
    assign bus.o_mem_we    = (w_win == TAG_CPU) && bus.i_cpu_we;
    assign bus.o_mem_addr  = w_addr;
    assign bus.o_mem_wdata = w_wdata;
    assign bus.o_rdata     = bus.i_mem_rdata;

    assign w_push = bus.o_mem_we ? TAG_NONE : w_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve  <= '0;
            r_rr_last <= 1'b1;
        end else begin
            if (!bus.i_cpu_req || bus.o_cpu_gnt)
                r_starve <= '0;
            else if (r_starve != CNT_W'(STARVE_MAX))
                r_starve <= r_starve + 1'b1;
            if (bus.o_cpu_gnt)
                r_rr_last <= 1'b1;
            else if (bus.o_rd_gnt)
                r_rr_last <= 1'b0;
        end
    end

    vram_return_pipe #(.MEM_LAT(MEM_LAT)) u_ret (
        .clk          (clk),
        .reset        (reset),
        .i_tag        (w_push),
        .o_so_rvalid  (bus.o_so_rvalid),
        .o_rd_rvalid  (bus.o_rd_rvalid),
        .o_cpu_rvalid (bus.o_cpu_rvalid)
    );

`ifdef VRAM_ARB_STATS_EN
    logic w_conflict;

    assign w_conflict = !reset && ((bus.i_so_req && bus.i_rd_req) ||
                                   (bus.i_so_req && bus.i_cpu_req) ||
                                   (bus.i_rd_req && bus.i_cpu_req));

    always_ff @(posedge clk) begin
        if (reset) begin
            o_stat_so_cnt       <= '0;
            o_stat_rd_cnt       <= '0;
            o_stat_cpu_cnt      <= '0;
            o_stat_conflict_cnt <= '0;
        end else begin
            o_stat_so_cnt       <= sat_inc16(o_stat_so_cnt, bus.o_so_gnt);
            o_stat_rd_cnt       <= sat_inc16(o_stat_rd_cnt, bus.o_rd_gnt);
            o_stat_cpu_cnt      <= sat_inc16(o_stat_cpu_cnt, bus.o_cpu_gnt);
            o_stat_conflict_cnt <= sat_inc16(o_stat_conflict_cnt, w_conflict);
        end
    end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: one instance at MEM_LAT=1 for the
// main traffic, one at MEM_LAT=3 for reset-while-in-flight.
module tb_vram_port_arbiter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    vram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus1 ();
    vram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus3 ();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] st_so, st_rd, st_cpu, st_cf;
    logic [15:0] st3_so, st3_rd, st3_cpu, st3_cf;
`endif

    vram_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
`ifdef VRAM_ARB_STATS_EN
        ,
        .o_stat_so_cnt       (st_so),
        .o_stat_rd_cnt       (st_rd),
        .o_stat_cpu_cnt      (st_cpu),
        .o_stat_conflict_cnt (st_cf)
`endif
    );

    vram_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
`ifdef VRAM_ARB_STATS_EN
        ,
        .o_stat_so_cnt       (st3_so),
        .o_stat_rd_cnt       (st3_rd),
        .o_stat_cpu_cnt      (st3_cpu),
        .o_stat_conflict_cnt (st3_cf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input logic [13:0] a);
        return 32'hC0DE_0000 ^ {18'h0, a};
    endfunction

    // Single-latency memory model with one remembered write
    logic        wr_valid = 1'b0;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;

    always @(posedge clk) begin
        if (bus1.o_mem_en && bus1.o_mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= bus1.o_mem_addr;
            wr_data  <= bus1.o_mem_wdata;
        end
        if (bus1.o_mem_en && !bus1.o_mem_we)
            bus1.i_mem_rdata <= (wr_valid && wr_addr == bus1.o_mem_addr) ? wr_data
                                                                       : mem_init(bus1.o_mem_addr);
    end

    assign bus3.i_mem_rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus1.i_so_req = 0; bus1.i_rd_req = 0; bus1.i_cpu_req = 0; bus1.i_cpu_we = 0;
        bus3.i_so_req = 0; bus3.i_rd_req = 0; bus3.i_cpu_req = 0; bus3.i_cpu_we = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 0;
        reset = 1;
        clear_reqs();
        bus1.i_so_addr = '0; bus1.i_rd_addr = '0; bus1.i_cpu_addr = '0; bus1.i_cpu_wdata = '0;
        bus3.i_so_addr = '0; bus3.i_rd_addr = '0; bus3.i_cpu_addr = '0; bus3.i_cpu_wdata = '0;
        tick();
        tick();

        // Requests during reset are ignored and the port is quiet
        bus1.i_so_req = 1; bus1.i_rd_req = 1; bus1.i_cpu_req = 1; bus1.i_cpu_we = 1;
        bus1.i_so_addr = 14'h0111; bus1.i_cpu_wdata = 32'h1234_5678;
        #1;
        chk("rst_gnt", {bus1.o_so_gnt, bus1.o_rd_gnt, bus1.o_cpu_gnt}, 3'b000);
        chk("rst_mem", {bus1.o_mem_en, bus1.o_mem_we}, 2'b00);
        chk("rst_addr", bus1.o_mem_addr, 14'h0);
        chk("rst_wdata", bus1.o_mem_wdata, 32'h0);
        chk("rst_rvalid", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b000);
        do_reset();

        // Render vs CPU alternate, render first after reset
        bus1.i_rd_req = 1; bus1.i_rd_addr = 14'h0040;
        bus1.i_cpu_req = 1; bus1.i_cpu_we = 0; bus1.i_cpu_addr = 14'h0041;
        #1; chk("rr1", {bus1.o_so_gnt, bus1.o_rd_gnt, bus1.o_cpu_gnt}, 3'b010);
        tick();
        #1; chk("rr2", {bus1.o_so_gnt, bus1.o_rd_gnt, bus1.o_cpu_gnt}, 3'b001);
        chk("rr2_rv", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b010);
        chk("rr2_data", bus1.o_rdata, 32'hC0DE_0040);
        tick();
        #1; chk("rr3", {bus1.o_so_gnt, bus1.o_rd_gnt, bus1.o_cpu_gnt}, 3'b010);
        chk("rr3_rv", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b001);
        chk("rr3_data", bus1.o_rdata, 32'hC0DE_0041);
        tick();
        #1; chk("rr4", {bus1.o_so_gnt, bus1.o_rd_gnt, bus1.o_cpu_gnt}, 3'b001);
        tick();
        clear_reqs();
        #1; chk("rr5_rv", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b001);
        chk("rr5_idle", bus1.o_mem_en, 1'b0);
        do_reset();

        // Single render read, latency 1
        bus1.i_rd_req = 1; bus1.i_rd_addr = 14'h0123;
        #1; chk("rd_gnt", {bus1.o_rd_gnt, bus1.o_mem_en, bus1.o_mem_we}, 3'b110);
        chk("rd_addr", bus1.o_mem_addr, 14'h0123);
        tick();
        bus1.i_rd_req = 0;
        #1; chk("rd_rv", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b010);
        chk("rd_data", bus1.o_rdata, 32'hC0DE_0123);
        tick();
        #1; chk("rd_rv_once", bus1.o_rd_rvalid, 1'b0);
        do_reset();

        // Scanout beats render for 4 cycles; render wins when scanout drops
        bus1.i_so_req = 1; bus1.i_so_addr = 14'h0200;
        bus1.i_rd_req = 1; bus1.i_rd_addr = 14'h0300;
        for (int i = 0; i < 4; i++) begin
            #1; chk("so_vs_rd", {bus1.o_so_gnt, bus1.o_rd_gnt}, 2'b10);
            tick();
        end
        bus1.i_so_req = 0;
        #1; chk("rd_after_so", {bus1.o_so_gnt, bus1.o_rd_gnt}, 2'b01);
        tick();
        bus1.i_rd_req = 0;
`ifdef VRAM_ARB_STATS_EN
        #1;
        chk("stat_so", st_so, 16'd4);
        chk("stat_rd", st_rd, 16'd1);
        chk("stat_cf", st_cf, 16'd4);
`endif
        do_reset();

        // Scanout vs CPU write: CPU forced on the 9th cycle
        bus1.i_so_req = 1; bus1.i_so_addr = 14'h0200;
        bus1.i_cpu_req = 1; bus1.i_cpu_we = 1; bus1.i_cpu_addr = 14'h0055;
        bus1.i_cpu_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            #1; chk("starve_so", {bus1.o_so_gnt, bus1.o_cpu_gnt}, 2'b10);
            if (i == 2) chk("so_data", bus1.o_rdata, 32'hC0DE_0200);
            tick();
        end
        #1; chk("starve_cpu", {bus1.o_so_gnt, bus1.o_cpu_gnt, bus1.o_mem_we}, 3'b011);
        chk("wr_addr", bus1.o_mem_addr, 14'h0055);
        chk("wr_data", bus1.o_mem_wdata, 32'hDEAD_BEEF);
        chk("wr_with_rv", bus1.o_so_rvalid, 1'b1);
        tick();
        bus1.i_cpu_req = 0; bus1.i_cpu_we = 0;
        #1; chk("so_resume", {bus1.o_so_gnt, bus1.o_mem_we}, 2'b10);
        chk("wr_no_rv", {bus1.o_so_rvalid, bus1.o_rd_rvalid, bus1.o_cpu_rvalid}, 3'b000);
        tick();
        bus1.i_so_req = 0;
        bus1.i_rd_req = 1; bus1.i_rd_addr = 14'h0055;
        #1; chk("rdback_gnt", bus1.o_rd_gnt, 1'b1);
        tick();
        bus1.i_rd_req = 0;
        #1; chk("rdback_rv", bus1.o_rd_rvalid, 1'b1);
        chk("rdback_data", bus1.o_rdata, 32'hDEAD_BEEF);
        do_reset();

        // MEM_LAT=3: reset one cycle after a CPU read discards it
        bus3.i_cpu_req = 1; bus3.i_cpu_we = 0; bus3.i_cpu_addr = 14'h0007;
        #1; chk("l3_gnt", bus3.o_cpu_gnt, 1'b1);
        tick();
        bus3.i_cpu_req = 0;
        bus3.i_so_req = 1;
        reset = 1;
        #1;
        chk("l3_rst_out", {bus3.o_so_gnt, bus3.o_rd_gnt, bus3.o_cpu_gnt, bus3.o_mem_en,
                           bus3.o_mem_we, bus3.o_so_rvalid, bus3.o_rd_rvalid,
                           bus3.o_cpu_rvalid}, 8'h00);
        chk("l3_rst_addr", bus3.o_mem_addr, 14'h0);
        tick();
        reset = 0;
        bus3.i_so_req = 0;
        for (int i = 0; i < 4; i++) begin
            #1; chk("l3_no_rv", bus3.o_cpu_rvalid, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port VRAM between three requesters: display scanout reads, render-pipeline fetches (tilemap, sprite and texture rows issued by the GPU controller), and CPU bus read/write accesses.
- Arbitrates every cycle and drives the memory port.
- Tracks in-flight reads with a tag pipeline so each read's data returns only to its issuer.
- Bounds CPU starvation with a counter.

Parameters:
- ADDR_W, 14, VRAM word-address width.
- DATA_W, 32, VRAM data width.
- MEM_LAT, 1, VRAM read latency in cycles (1..4).
- STARVE_MAX, 8, consecutive denied CPU request cycles before the CPU is forced to win.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- i_so_req  in  1  scanout read request.
- i_so_addr  in  ADDR_W  scanout address.
- o_so_gnt  out  1  scanout request accepted this cycle.
- o_so_rvalid  out  1  scanout read data valid.
- i_rd_req  in  1  render fetch request.
- i_rd_addr  in  ADDR_W  render address.
- o_rd_gnt  out  1  render request accepted.
- o_rd_rvalid  out  1  render read data valid.
- i_cpu_req  in  1  CPU request.
- i_cpu_we  in  1  CPU write (1) / read (0).
- i_cpu_addr  in  ADDR_W  CPU address.
- i_cpu_wdata  in  DATA_W  CPU write data.
- o_cpu_gnt  out  1  CPU request accepted.
- o_cpu_rvalid  out  1  CPU read data valid.
- o_rdata  out  DATA_W  shared read data, equal to i_mem_rdata.
- o_mem_en  out  1  VRAM enable.
- o_mem_we  out  1  VRAM write enable.
- o_mem_addr  out  ADDR_W  VRAM address.
- o_mem_wdata  out  DATA_W  VRAM write data.
- i_mem_rdata  in  DATA_W  VRAM read data, valid MEM_LAT cycles after o_mem_en with o_mem_we=0.

Behaviour:
- Handshake:
  - Requester holds req/addr (and we/wdata) stable until it sees gnt high.
  - gnt is combinational, single-cycle, at most one per cycle, and coincides with o_mem_en=1.
  - Next request may be presented in the cycle after gnt.
- Memory port:
  - Combinationally driven from the winner.
  - o_mem_we=1 only for a CPU grant with i_cpu_we=1.
  - With no winner: o_mem_en=0 and o_mem_we=0.
- Priority, evaluated each cycle:
  1. CPU, if starve_cnt==STARVE_MAX and i_cpu_req.
  2. Scanout.
  3. Render vs CPU, round-robin via rr_last (1 = CPU won last): the one not in rr_last wins when both request; a sole requester always wins.
- rr_last updates only on a render or CPU grant.
- starve_cnt:
  - Increments while i_cpu_req=1 and o_cpu_gnt=0, saturating at STARVE_MAX.
  - Clears on a CPU grant or when i_cpu_req=0.
- Return tags:
  - MEM_LAT-deep shift register of 2-bit tags {NONE, SO, RD, CPU}.
  - A read grant pushes the winner's tag; a write or idle cycle pushes NONE.
  - The tag at the output stage asserts exactly one of o_so_rvalid / o_rd_rvalid / o_cpu_rvalid for one cycle.
  - Read latency is exactly MEM_LAT cycles from gnt to rvalid.
  - Back-to-back reads sustain 1 per cycle.
- Reset:
  - All gnt/rvalid = 0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - Tag pipe all NONE, starve_cnt=0, rr_last=1 (render wins the first tie).
  - Reset mid-flight discards pending reads: no rvalid is produced for them after reset.
  - Requests are ignored while reset=1.
- Boundaries:
  - All three requesting: scanout wins unless starvation is forced.
  - Starvation forcing preempts scanout for one cycle only, then starve_cnt=0.
  - A CPU write in the same cycle a read returns is legal; the rvalid still fires.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds ports o_stat_so_cnt, o_stat_rd_cnt, o_stat_cpu_cnt, o_stat_conflict_cnt (each 16-bit out).
- These count grants per requester and cycles with 2 or more simultaneous requests.
- Counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (vram_arb_pkg):
  - Tag encoding constants: TAG_NONE=0, TAG_SO=1, TAG_RD=2, TAG_CPU=3.
  - Default ADDR_W/DATA_W.
- One sub-module, vram_return_pipe:
  - Parameterised MEM_LAT-deep tag shift register with one-hot rvalid decode.
  - Instantiated once.

Test Plan:
- Single render read at addr 0x0123, MEM_LAT=1 -> o_rd_gnt same cycle with o_mem_addr=0x0123; o_rd_rvalid exactly 1 cycle later with o_rdata equal to the memory model word.
- Scanout and render both request continuously for 4 cycles -> scanout granted all 4; render granted the cycle scanout drops.
- Render and CPU both held requesting, no scanout -> grants alternate RD, CPU, RD, CPU, starting with RD after reset.
- Scanout and CPU held continuously, STARVE_MAX=8 -> CPU granted on the 9th cycle (starve_cnt hits 8), then scanout resumes.
- MEM_LAT=3, CPU read granted, then reset asserted 1 cycle later for 1 cycle -> no o_cpu_rvalid ever appears; all outputs 0 during reset.
- With VRAM_ARB_STATS_EN, 10 scanout grants and 3 conflict cycles -> o_stat_so_cnt=10, o_stat_conflict_cnt=3.
